// File: rtl/irq_priority_ctrl8.sv
// irq_priority_ctrl8: 8-channel interrupt request controller.
// Latches edge- or level-triggered requests into a pending register and
// applies a programmable mask. It picks the highest-index unmasked
// request, presents it over a valid/ack handshake, and then holds
// in-service state until end-of-interrupt.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   S_IDLE    | nothing outstanding; waiting for an unmasked pending bit
//   S_REQ     | vector presented (o_valid = 1), frozen until i_ack
//   S_SERVICE | vector acked, consumer servicing; waiting for i_eoi
module irq_priority_ctrl8 #(
    parameter bit EDGE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_irq,
    input  logic       i_mask_wr,
    input  logic [7:0] i_mask_in,
    input  logic       i_ack,
    input  logic       i_eoi,
    output logic       o_valid,
    output logic [2:0] o_vec,
    output logic [7:0] o_pending,
    output logic [7:0] o_mask,
    output logic       o_in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pending;
    logic [7:0] r_irq_d;
    logic [7:0] r_mask;
    logic [2:0] r_vec;

    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [7:0] w_cand;
    logic [2:0] w_sel;
    logic       w_vec_load;

    // Request set term and the unmasked candidate set.
    always_comb begin
        w_set  = EDGE ? (i_irq & ~r_irq_d) : i_irq;
        w_cand = r_pending & ~r_mask;
    end

    // Fixed priority: the highest set candidate bit wins (bit 7 highest).
    always_comb begin
        w_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_cand[i]) begin
                w_sel = i[2:0];
            end
        end
    end

    // Next-state logic; the ack clears exactly the presented channel.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 8'h00;
        w_vec_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cand != 8'h00) begin
                    w_vec_load  = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (i_ack) begin
                    w_clr        = 8'h00;
                    w_clr[r_vec] = 1'b1;
                    w_state_nxt  = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (i_eoi) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pending, mask and vector registers. Set beats clear on a bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pending <= 8'h00;
            r_irq_d   <= 8'h00;
            r_mask    <= 8'h00;
            r_vec     <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_irq_d   <= i_irq;
            if (i_mask_wr) begin
                r_mask <= i_mask_in;
            end
            if (w_vec_load) begin
                r_vec <= w_sel;
            end
        end
    end

    assign o_valid      = (r_state == S_REQ);
    assign o_in_service = (r_state == S_SERVICE);
    assign o_vec        = r_vec;
    assign o_pending    = r_pending;
    assign o_mask       = r_mask;

endmodule

// File: doc/irq_priority_ctrl8.md
# irq_priority_ctrl8

8-input interrupt request controller that sits directly upstream of the 8:3 priority encoding stage. It latches edge- or level-triggered requests into a pending register and applies a programmable mask. It selects the highest-index unmasked request using the same priority order as the encoder (bit 7 highest, `1xxxxxxx -> 111`). It then presents the 3-bit vector to a consumer through a valid/ack handshake and holds in-service state until end-of-interrupt.

## Interface
- `EDGE`, default 1: 1 = a request latches on a rising edge of `irq[i]`; 0 = a request latches whenever `irq[i]` is high (level).
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `irq`, in, 8: raw request lines. Already synchronous to `clk`.
- `mask_wr`, in, 1: load `mask` from `mask_in` this cycle.
- `mask_in`, in, 8: new mask value; bit = 1 disables that channel.
- `ack`, in, 1: consumer accepts the presented vector. Honoured only while `valid` = 1.
- `eoi`, in, 1: end of interrupt. Honoured only in SERVICE.
- `valid`, out, 1: `vec` is a pending, unacknowledged request.
- `vec`, out, 3: index of the selected channel. Registered.
- `pending`, out, 8: pending register (visibility and debug).
- `mask`, out, 8: current mask register.
- `in_service`, out, 1: a vector has been acked and `eoi` has not yet arrived.

## Operation
- Reset values: `pending` = 0, `mask` = 0 (all channels enabled), `valid` = 0, `vec` = 0, `in_service` = 0, state = IDLE, internal `irq_d` = 0.
- Latching: set term = `irq & ~irq_d` (EDGE=1) or `irq` (EDGE=0).
  - Each clock: `pending <= (pending & ~clr) | set`, and `irq_d <= irq`.
  - Set wins over clear on the same bit in the same cycle.
  - Because `irq_d` resets to 0, an `irq` line already high on the first post-reset cycle counts as an edge.
- Masking: masked requests still latch into `pending`. Candidate set = `pending & ~mask`. Clearing a mask bit releases any already-latched request on that channel.
- Selection: `vec` = index of the highest set bit of the candidate set. Plain priority encoding; no rotation.
- FSM states:
  - IDLE: if the candidate set is nonzero, register `vec` and go to REQ (`valid` = 1). Otherwise stay.
  - REQ: `valid` = 1; `vec` is frozen. A newly arriving higher-priority request does not pre-empt, and a mask write does not withdraw the request.
    - On `ack`: `clr` = one-hot(`vec`), go to SERVICE.
  - SERVICE: `valid` = 0, `in_service` = 1. On `eoi`: go to IDLE.
- Ignored inputs: `ack` outside REQ; `eoi` outside SERVICE.
- No nesting: at most one vector is outstanding or in service.
- `mask_wr` takes effect at the edge it is sampled, in any state, simultaneously with any other event.

## Timing
- Request to valid: `irq` edge sampled at clock edge n sets `pending` at n. `valid` and `vec` go high at n+1 (1-cycle registered output after latch).
- Ack: `ack` = 1 with `valid` = 1 at edge m:
  - `valid` falls, `in_service` rises, and the `pending` bit clears at m.
- EOI: `eoi` at edge k returns the FSM to IDLE at k. The next `valid`, if a candidate exists, is at k+1. Minimum spacing between successive vectors is therefore 3 cycles.
- Level mode: if `irq[i]` is still high when the ack clears the bit, the set term re-latches it in the same cycle. The channel re-requests after `eoi`.
- `rst` in any state: all outputs and registers return to their reset values at that edge. Any outstanding vector is discarded; no `eoi` is required.

## Test plan
- Single edge, EDGE=1: `irq` = 0x01 for one cycle.
  - Required: `valid` = 1, `vec` = 0 one cycle later.
  - `ack`: `pending` = 0x00, `in_service` = 1.
  - `eoi`: back to IDLE, `valid` stays 0.
- Priority: `irq` = 0x5A in one cycle.
  - Required: `vec` = 6.
  - After ack/eoi: `vec` = 4, then 3, then 1, with `pending` stepping 0x5A -> 0x1A -> 0x0A -> 0x02 -> 0x00.
- Masking: `mask` = 0xF0, then `irq` = 0xF3.
  - Required: `vec` = 1 then 0.
  - `pending` holds 0xF0 with `valid` = 0.
  - Writing `mask` = 0x00: `vec` = 7 next cycle.
- No pre-emption: in REQ with `vec` = 2, pulse `irq[7]`.
  - Required: `vec` stays 2 until ack; `vec` = 7 is presented only after `eoi`.
- Same-cycle set/clear, EDGE=0: `irq[3]` held high, ack `vec` = 3.
  - Required: `pending[3]` stays 1; `vec` = 3 is re-presented one cycle after `eoi`.
- Reset mid-operation: assert `rst` in SERVICE.
  - Required: next cycle `valid` = 0, `in_service` = 0, `pending` = 0, `mask` = 0.
  - With `irq` = 0x80 held high across reset, `vec` = 7 appears 2 cycles after `rst` deasserts.
